// File: rtl/addsub_seq_ctrl.sv
// Nibble-serial add/sub sequencer: one 4-bit slice reused across WIDTH/4 passes.
// Optional signed-overflow output is enabled by defining OVF_DETECT_EN.
module addsub_seq_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic             ci,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             co,
    output logic             ovf
);

    localparam int NIB = WIDTH / 4;
    localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [CW-1:0] LAST = CW'(NIB - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             sub_q, sub_d;
    logic             carry_q, carry_d;
    logic             co_q, co_d;
    logic [3:0]       bn;
    logic [4:0]       slice;

    // Operands shift right each pass, so the slice always reads the low nibble.
    assign bn    = b_q[3:0] ^ {4{sub_q}};
    assign slice = {1'b0, a_q[3:0]} + {1'b0, bn} + {4'b0, carry_q};

`ifdef OVF_DETECT_EN
    logic ovf_q, ovf_d;
    logic c3;
    assign c3 = a_q[3] ^ bn[3] ^ slice[3];
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        s_d     = s_q;
        sub_d   = sub_q;
        carry_d = carry_q;
        co_d    = co_q;
`ifdef OVF_DETECT_EN
        ovf_d   = ovf_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (start) state_d = RUN;
            end
            RUN: begin
                cnt_d   = cnt_q + CW'(1);
                a_d     = a_q >> 4;
                b_d     = b_q >> 4;
                res_d   = (res_q >> 4) | (WIDTH'(slice[3:0]) << (WIDTH - 4));
                carry_d = slice[4];
                if (cnt_q == LAST) begin
                    state_d = DONE;
                    s_d     = res_d;
                    co_d    = slice[4];
`ifdef OVF_DETECT_EN
                    ovf_d   = c3 ^ slice[4];
`endif
                end
            end
            DONE: begin
                state_d = start ? RUN : IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Nibble-0 carry-in is preloaded so every pass uses the carry register.
        if (start && state_q != RUN) begin
            a_d     = a;
            b_d     = b;
            sub_d   = sub;
            carry_d = ci ^ sub;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            s_q     <= '0;
            sub_q   <= 1'b0;
            carry_q <= 1'b0;
            co_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            s_q     <= s_d;
            sub_q   <= sub_d;
            carry_q <= carry_d;
            co_q    <= co_d;
        end
    end

`ifdef OVF_DETECT_EN
    always_ff @(posedge clk) begin
        if (rst) ovf_q <= 1'b0;
        else     ovf_q <= ovf_d;
    end
    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign s    = s_q;
    assign co   = co_q;

endmodule

// File: tb/tb_addsub_seq_ctrl.sv
// Directed bench for addsub_seq_ctrl at WIDTH=16.
// Define OVF_DETECT_EN for both bench and RTL to exercise the overflow output.
module tb_addsub_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        sub;
    logic        ci;
    logic [15:0] a;
    logic [15:0] b;
    logic        busy;
    logic        done;
    logic [15:0] s;
    logic        co;
    logic        ovf;

    int checks   = 0;
    int failures = 0;

`ifdef OVF_DETECT_EN
    localparam bit OVF_ON = 1'b1;
`else
    localparam bit OVF_ON = 1'b0;
`endif

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        sub;
        logic        ci;
        logic [15:0] s;
        logic        co;
        logic        ovf;
    } vec_t;

    always #5 clk = ~clk;

    addsub_seq_ctrl #(.WIDTH(16)) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .sub  (sub),
        .ci   (ci),
        .a    (a),
        .b    (b),
        .busy (busy),
        .done (done),
        .s    (s),
        .co   (co),
        .ovf  (ovf)
    );

    // Called at a negedge; returns at the next negedge with start dropped.
    task automatic launch(input vec_t v);
        a     = v.a;
        b     = v.b;
        sub   = v.sub;
        ci    = v.ci;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // lat counts negedges since the start edge; 5 means done after 5 edges.
    task automatic wait_done(output int lat);
        lat = 1;
        while (!done && lat < 12) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset;
        rst   = 1'b1;
        start = 1'b0;
        sub   = 1'b0;
        ci    = 1'b0;
        a     = '0;
        b     = '0;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({busy, done, co, ovf} !== 4'b0000 || s !== 16'h0000) begin
            failures++;
            $display("FAIL reset: busy=%b done=%b s=%h co=%b ovf=%b want all 0",
                     busy, done, s, co, ovf);
        end
    endtask

    task automatic test_add;
        vec_t tbl[2];
        int   lat;
        tbl[0] = '{16'h1234, 16'h0FFF, 1'b0, 1'b0, 16'h2233, 1'b0, 1'b0};
        tbl[1] = '{16'hFFFF, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
        foreach (tbl[i]) begin
            launch(tbl[i]);
            checks++;
            if (busy !== 1'b1 || done !== 1'b0) begin
                failures++;
                $display("FAIL add%0d_busy: busy=%b done=%b want 1 0",
                         i, busy, done);
            end
            wait_done(lat);
            checks++;
            if (lat !== 5) begin
                failures++;
                $display("FAIL add%0d_latency: got %0d want 5", i, lat);
            end
            checks++;
            if (s !== tbl[i].s || co !== tbl[i].co) begin
                failures++;
                $display("FAIL add%0d_result: s=%h co=%b want s=%h co=%b",
                         i, s, co, tbl[i].s, tbl[i].co);
            end
            checks++;
            if (ovf !== (tbl[i].ovf & OVF_ON)) begin
                failures++;
                $display("FAIL add%0d_ovf: got %b want %b",
                         i, ovf, tbl[i].ovf & OVF_ON);
            end
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || busy !== 1'b0 || s !== tbl[i].s) begin
                failures++;
                $display("FAIL add%0d_pulse: done=%b busy=%b s=%h want 0 0 %h",
                         i, done, busy, s, tbl[i].s);
            end
        end
    endtask

    task automatic test_sub;
        vec_t tbl[3];
        int   lat;
        tbl[0] = '{16'h1000, 16'h0001, 1'b1, 1'b0, 16'h0FFF, 1'b1, 1'b0};
        tbl[1] = '{16'h0000, 16'h0001, 1'b1, 1'b0, 16'hFFFF, 1'b0, 1'b0};
        tbl[2] = '{16'h0005, 16'h0003, 1'b1, 1'b1, 16'h0001, 1'b1, 1'b0};
        foreach (tbl[i]) begin
            launch(tbl[i]);
            wait_done(lat);
            checks++;
            if (lat !== 5 || s !== tbl[i].s || co !== tbl[i].co) begin
                failures++;
                $display("FAIL sub%0d: lat=%0d s=%h co=%b want 5 %h %b",
                         i, lat, s, co, tbl[i].s, tbl[i].co);
            end
            checks++;
            if (ovf !== (tbl[i].ovf & OVF_ON)) begin
                failures++;
                $display("FAIL sub%0d_ovf: got %b want %b",
                         i, ovf, tbl[i].ovf & OVF_ON);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_ovf;
        vec_t tbl[3];
        int   lat;
        tbl[0] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        tbl[1] = '{16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1};
        tbl[2] = '{16'h0005, 16'h0003, 1'b1, 1'b0, 16'h0002, 1'b1, 1'b0};
        foreach (tbl[i]) begin
            launch(tbl[i]);
            wait_done(lat);
            checks++;
            if (lat !== 5 || s !== tbl[i].s || co !== tbl[i].co) begin
                failures++;
                $display("FAIL ovf%0d_result: lat=%0d s=%h co=%b want 5 %h %b",
                         i, lat, s, co, tbl[i].s, tbl[i].co);
            end
            checks++;
            if (ovf !== (tbl[i].ovf & OVF_ON)) begin
                failures++;
                $display("FAIL ovf%0d: got %b want %b",
                         i, ovf, tbl[i].ovf & OVF_ON);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back;
        vec_t v0;
        vec_t v1;
        int   lat;
        v0 = '{16'h1111, 16'h2222, 1'b0, 1'b0, 16'h3333, 1'b0, 1'b0};
        v1 = '{16'h0100, 16'h0011, 1'b0, 1'b0, 16'h0111, 1'b0, 1'b0};
        launch(v0);
        a     = 16'hFFFF;
        b     = 16'hFFFF;
        ci    = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat   = 2;
        while (!done && lat < 12) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (lat !== 5 || s !== 16'h3333 || co !== 1'b0) begin
            failures++;
            $display("FAIL ignore_start: lat=%0d s=%h co=%b want 5 3333 0",
                     lat, s, co);
        end
        launch(v1);
        checks++;
        if (busy !== 1'b1 || s !== 16'h3333) begin
            failures++;
            $display("FAIL b2b_hold: busy=%b s=%h want 1 3333", busy, s);
        end
        wait_done(lat);
        checks++;
        if (lat !== 5 || s !== v1.s || co !== v1.co) begin
            failures++;
            $display("FAIL b2b_result: lat=%0d s=%h co=%b want 5 %h %b",
                     lat, s, co, v1.s, v1.co);
        end
        @(negedge clk);
    endtask

    task automatic test_rst_mid_run;
        vec_t v0;
        vec_t v1;
        int   lat;
        v0 = '{16'h8888, 16'h8888, 1'b0, 1'b0, 16'h1110, 1'b1, 1'b1};
        v1 = '{16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0};
        launch(v0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({busy, done, co, ovf} !== 4'b0000 || s !== 16'h0000) begin
            failures++;
            $display("FAIL rst_mid_run: busy=%b done=%b s=%h co=%b ovf=%b want 0",
                     busy, done, s, co, ovf);
        end
        launch(v1);
        wait_done(lat);
        checks++;
        if (lat !== 5 || s !== v1.s || co !== v1.co || ovf !== 1'b0) begin
            failures++;
            $display("FAIL after_rst: lat=%0d s=%h co=%b ovf=%b want 5 %h %b 0",
                     lat, s, co, ovf, v1.s, v1.co);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_ovf();
        test_back_to_back();
        test_rst_mid_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
